// File: rtl/prewish_pkg.sv
// Shared helpers and default geometry for the multi-channel mask blinker.
package prewish_pkg;

   localparam int DEF_MASK_W        = 8;
   localparam int DEF_PRESCALE_BITS = 9;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prewish_mb_channel.sv
// One LED channel: double-buffered mask (shadow/pending) feeding a rotating active register.
module prewish_mb_channel
   import prewish_pkg::*;
#(
   parameter int MASK_W = DEF_MASK_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              wr_en,
   input  logic [MASK_W-1:0] wr_data,
   input  logic              tick,
   input  logic              frame_end,
   output logic              led,
   output logic [MASK_W-1:0] active
);

   logic [MASK_W-1:0] r_shadow;
   logic [MASK_W-1:0] r_active;
   logic              r_pending;
   logic              w_load;

   assign w_load = tick & frame_end & r_pending;

   // A write on the load edge lands in shadow after the load has taken the old value,
   // and keeps pending set so the new mask plays from the following frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shadow  <= '0;
         r_active  <= '0;
         r_pending <= 1'b0;
      end else begin
         if (w_load) begin
            r_active <= r_shadow;
         end else if (tick) begin
            r_active <= {r_active[MASK_W-2:0], r_active[MASK_W-1]};
         end
         if (wr_en) begin
            r_shadow  <= wr_data;
            r_pending <= 1'b1;
         end else if (w_load) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign led    = r_active[MASK_W-1];
   assign active = r_active;

endmodule

// File: rtl/prewish_multiblinker.sv
// Multi-channel mask blinker: strobe write port, shared prescaler/bit index, NUM_CH channels.
// Optional readback of the pre-write active mask on DAT_O when PREWISH_MB_READBACK_EN is defined.
module prewish_multiblinker
   import prewish_pkg::*;
#(
   parameter  int NUM_CH        = 4,
   parameter  int MASK_W        = DEF_MASK_W,
   parameter  int PRESCALE_BITS = DEF_PRESCALE_BITS,
   localparam int ADR_W         = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              STB_I,
   input  logic [ADR_W-1:0]  ADR_I,
   input  logic [MASK_W-1:0] DAT_I,
   output logic              ACK_O,
`ifdef PREWISH_MB_READBACK_EN
   output logic [MASK_W-1:0] DAT_O,
`endif
   output logic [NUM_CH-1:0] o_led
);

   localparam int                BIT_W    = clog2(MASK_W);
   localparam logic [ADR_W:0]    NUM_CH_L = (ADR_W + 1)'(NUM_CH);
   localparam logic [BIT_W-1:0]  LAST_IDX = BIT_W'(MASK_W - 1);

   logic                     r_stb_q;
   logic                     r_ack;
   logic [PRESCALE_BITS-1:0] r_presc;
   logic [BIT_W-1:0]         r_bit_idx;

   logic                     w_accept;
   logic                     w_in_range;
   logic                     w_tick;
   logic                     w_frame_end;
   logic [NUM_CH-1:0]        w_wr_en;

   assign w_accept    = STB_I & ~r_stb_q;
   assign w_in_range  = {1'b0, ADR_I} < NUM_CH_L;
   assign w_tick      = &r_presc;
   assign w_frame_end = w_tick && (r_bit_idx == LAST_IDX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stb_q   <= 1'b0;
         r_ack     <= 1'b0;
         r_presc   <= '0;
         r_bit_idx <= '0;
      end else begin
         r_stb_q <= STB_I;
         r_ack   <= w_accept;
         r_presc <= r_presc + 1'b1;
         if (w_tick) begin
            r_bit_idx <= (r_bit_idx == LAST_IDX) ? '0 : r_bit_idx + 1'b1;
         end
      end
   end

   assign ACK_O = r_ack;

`ifdef PREWISH_MB_READBACK_EN
   logic [MASK_W-1:0] w_active [NUM_CH];
   logic [MASK_W-1:0] r_dat;

   // Captures the mask as it stood before the accept edge; out-of-range reads give 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dat <= '0;
      end else if (w_accept) begin
         r_dat <= w_in_range ? w_active[ADR_I] : '0;
      end
   end

   assign DAT_O = r_dat;
`endif

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign w_wr_en[gi] = w_accept && w_in_range && (ADR_I == ADR_W'(gi));

         prewish_mb_channel #(
            .MASK_W    (MASK_W)
         ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .wr_en     (w_wr_en[gi]),
            .wr_data   (DAT_I),
            .tick      (w_tick),
            .frame_end (w_frame_end),
            .led       (o_led[gi]),
`ifdef PREWISH_MB_READBACK_EN
            .active    (w_active[gi])
`else
            .active    ()
`endif
         );
      end
   endgenerate

endmodule

// File: tb/tb_prewish_multiblinker.sv
// Directed bench for prewish_multiblinker (4 channels, 8-bit masks, tick every 4 clocks).
module tb_prewish_multiblinker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stb;
   logic [1:0] adr;
   logic [7:0] dat;
   logic       ack;
   logic [3:0] led;
`ifdef PREWISH_MB_READBACK_EN
   logic [7:0] dat_o;
`endif

   int n_checks = 0;
   int n_err    = 0;
   int cnt;

   always #5 clk = ~clk;

   // Bench-side edge counter: cnt == k right after the k-th rising edge since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= 0;
      else        cnt <= cnt + 1;
   end

   prewish_multiblinker #(
      .NUM_CH        (4),
      .MASK_W        (8),
      .PRESCALE_BITS (2)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .STB_I   (stb),
      .ADR_I   (adr),
      .DAT_I   (dat),
      .ACK_O   (ack),
`ifdef PREWISH_MB_READBACK_EN
      .DAT_O   (dat_o),
`endif
      .o_led   (led)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic goto(input int k);
      while (cnt < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int k, input logic [1:0] a, input logic [7:0] d);
      goto(k);
      stb = 1'b1;
      adr = a;
      dat = d;
      goto(k + 1);
      chk($sformatf("ack_hi_e%0d", k + 1), 32'(ack), 32'd1);
      stb = 1'b0;
      goto(k + 2);
      chk($sformatf("ack_lo_e%0d", k + 2), 32'(ack), 32'd0);
      $display("wr ch%0d data %02h accepted at edge %0d", a, d, k + 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] seen;
      logic [8:0] seq_a;
      logic [7:0] seq_m;
      int         acks;

      stb = 1'b0;
      adr = 2'd0;
      dat = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_led", 32'(led), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
`ifdef PREWISH_MB_READBACK_EN
      chk("rst_dat", 32'(dat_o), 32'h0);
`endif
      rst_n = 1'b1;

      seen = '0;
      for (int i = 1; i <= 200; i++) begin
         goto(i);
         seen = seen | led;
      end
      chk("idle_led", 32'(seen), 32'h0);

      // ch0 = A8: visible from boundary edge 224, one bit per 4 clocks, then repeats
      wr(200, 2'd0, 8'hA8);
      goto(223);
      chk("a8_before", 32'(led), 32'h0);
      seq_a = 9'b101010001;
      for (int j = 0; j < 9; j++) begin
         goto(225 + 4 * j);
         chk($sformatf("a8_bit%0d", j), 32'(led), {31'd0, seq_a[8 - j]});
      end

      // ch1 = FF with a 20-cycle strobe: one acknowledge only
      goto(260);
      stb = 1'b1;
      adr = 2'd1;
      dat = 8'hFF;
      acks = 0;
      for (int i = 1; i <= 25; i++) begin
         goto(260 + i);
         acks = acks + int'(ack);
         if (i == 20) stb = 1'b0;
      end
      $display("wr ch1 data ff long strobe, %0d ack cycles", acks);
      chk("long_acks", 32'(acks), 32'd1);
      goto(289);
      chk("ff_e289", 32'(led), 32'h3);
      goto(293);
      chk("ff_e293", 32'(led), 32'h2);

      // ch2: 0F then F0 in the same frame; only F0 plays
      wr(300, 2'd2, 8'h0F);
      wr(305, 2'd2, 8'hF0);
      goto(319);
      chk("f0_before", 32'(led[2]), 32'h0);
      seq_m = 8'hF0;
      for (int j = 0; j < 8; j++) begin
         goto(321 + 4 * j);
         chk($sformatf("f0_bit%0d", j), 32'(led[2]), {31'd0, seq_m[7 - j]});
      end

      // ch3: 01 pending, then 80 accepted on the boundary edge 384
      wr(355, 2'd3, 8'h01);
      wr(383, 2'd3, 8'h80);
      seq_m = 8'h01;
      for (int j = 0; j < 8; j++) begin
         goto(385 + 4 * j);
         chk($sformatf("coll01_bit%0d", j), 32'(led[3]), {31'd0, seq_m[7 - j]});
      end
      goto(417);
      chk("coll80_bit0", 32'(led[3]), 32'h1);
      goto(421);
      chk("coll80_bit1", 32'(led[3]), 32'h0);

      // ch0 write while A8 plays; active was A8 rotated left by 3
      wr(429, 2'd0, 8'hA8);
`ifdef PREWISH_MB_READBACK_EN
      chk("rdbk_e431", 32'(dat_o), 32'h45);
      goto(440);
      chk("rdbk_hold", 32'(dat_o), 32'h45);
`endif

      goto(461);
      chk("run_e461", 32'(led), 32'h6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_led", 32'(led), 32'h0);
      chk("async_ack", 32'(ack), 32'h0);
`ifdef PREWISH_MB_READBACK_EN
      chk("async_dat", 32'(dat_o), 32'h0);
`endif
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      seen = '0;
      for (int i = 1; i <= 100; i++) begin
         goto(i);
         seen = seen | led;
      end
      chk("post_rst_idle", 32'(seen), 32'h0);

      // First boundary after release is edge 32; accept at 101 becomes visible at 128
      wr(100, 2'd0, 8'hFF);
      goto(127);
      chk("rel_e127", 32'(led), 32'h0);
      goto(129);
      chk("rel_e129", 32'(led), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/prewish_multiblinker.md
# prewish_multiblinker

Multi-channel successor to the single-LED mask blinker built under `prewish_controller`. It holds `NUM_CH` independent `MASK_W`-bit blink patterns, loaded over a strobe/data/ack write port, and rotates each pattern out on its LED at a rate set by a shared prescaler. Mask changes are double-buffered so a pattern is only ever replaced on a frame boundary. The block sits behind the system controller, driven from its clock and reset, in place of the single-channel blinker.

## Interface
- `NUM_CH`, 4: number of LED channels, 1..16.
- `MASK_W`, 8: mask width in bits; power of two, 2..32.
- `PRESCALE_BITS`, 9: width of the prescaler; one shift tick every 2^`PRESCALE_BITS` clocks; minimum 1.
- `i_clk`  in  1: system clock; all state on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous assert, active-low.
- `STB_I`  in  1: write strobe; level input, edge-detected internally.
- `ADR_I`  in  clog2(`NUM_CH`), minimum 1: target channel.
- `DAT_I`  in  `MASK_W`: new mask.
- `ACK_O`  out  1: one-cycle write acknowledge.
- `DAT_O`  out  `MASK_W`: readback data. Present only with `PREWISH_MB_READBACK_EN`.
- `o_led`  out  `NUM_CH`: active-high LED drive; bit c is the MSB of the channel c active register.

## Operation
- Reset (asynchronous, `i_rst_n`=0): prescaler, bit index, `stb_q`, all shadow, active and pending registers, `ACK_O`, `DAT_O` and `o_led` clear to 0.
- Write accept: on a clock edge where `STB_I`=1 and `stb_q`=0.
  - `DAT_I` is stored into shadow[`ADR_I`] and pending[`ADR_I`] is set.
  - A strobe held high for any number of cycles is exactly one write. `STB_I` must return low before the next write is accepted.
- Out-of-range address (`ADR_I` ≥ `NUM_CH`): the write is dropped and still acknowledged.
- Repeated writes to one channel within a frame: the last write wins.
- Prescaler: free-running `PRESCALE_BITS` counter. A tick occurs on the cycle it equals all-ones; it then wraps to 0.
- Bit index: clog2(`MASK_W`) counter, advanced on each tick and wrapping at `MASK_W`-1.
  - A frame boundary is a tick while the index equals `MASK_W`-1.
- Each tick, every channel rotates its active register left by 1, so the MSB re-enters at the LSB and the pattern repeats indefinitely.
- At a frame boundary, each channel with pending=1 instead loads active from shadow and clears pending. Channels with pending=0 rotate as normal.
- Simultaneous write accept and boundary load on the same channel:
  - the load takes the old shadow;
  - the new data lands in shadow;
  - pending stays 1, so the new mask plays from the following frame.
- All channels share one prescaler and one bit index, so frames are phase-aligned across channels.

## Timing
- `ACK_O`: high for exactly the single cycle after the accept edge; low otherwise.
- Earliest visibility: the write is visible on `o_led` at the first frame-boundary edge strictly after the accept edge. Worst case is `MASK_W`·2^`PRESCALE_BITS` cycles.
- Each mask bit is held for 2^`PRESCALE_BITS` cycles. The first bit shown after a load is the mask MSB.
- `o_led` is registered with no combinational path from any input.
- `i_rst_n` deassertion: the prescaler starts counting on the first edge where `i_rst_n`=1. The first tick occurs 2^`PRESCALE_BITS` edges later.

## Configuration
- `PREWISH_MB_READBACK_EN` defined: the `DAT_O` port exists.
  - On a write accept, `DAT_O` registers the active mask of `ADR_I` as it was before the edge, valid alongside `ACK_O`.
  - For an out-of-range address, `DAT_O` is 0.
  - `DAT_O` holds its value until the next accept.
- `PREWISH_MB_READBACK_EN` undefined: no `DAT_O` port and no readback mux. All other behaviour is identical.

## Structure
- Package `prewish_pkg`: the clog2 helper function and the default values of `MASK_W` and `PRESCALE_BITS`.
- Sub-module `prewish_mb_channel`, instanced `NUM_CH` times. It contains the shadow, active and pending registers.
  - Inputs: `wr_en`, `wr_data`, `tick`, `frame_end`.
  - Outputs: `led`, `active`.
- The top level contains the strobe edge detector, `ACK_O`, the prescaler, the bit index, address decode and the readback mux.

## Test plan
All scenarios use `NUM_CH`=4, `MASK_W`=8, `PRESCALE_BITS`=2 (tick every 4 clocks).
- Reset: pulse `i_rst_n` low for 3 cycles -> `o_led`=4'b0000 and `ACK_O`=0; no LED activity for 200 cycles.
- Basic pattern: write ch0 = 8'hA8 -> `ACK_O` high 1 cycle later for 1 cycle. From the next frame boundary, `o_led[0]` follows 1,0,1,0,1,0,0,0, each bit held 4 clocks, repeating. `o_led[3:1]` stay 0.
- Long strobe: `STB_I` held high 20 cycles with ch1 = 8'hFF -> exactly one `ACK_O` pulse; `o_led[1]` steady 1 after the boundary.
- Last write wins: write ch2 = 8'h0F, then ch2 = 8'hF0, within one frame -> ch2 plays 8'hF0; 8'h0F never appears.
- Boundary collision: time an accept for ch3 = 8'h80 on the same edge as a boundary load of ch3 = 8'h01. Ch3 plays 8'h01 for one frame, then 8'h80.
- Reset mid-frame and readback:
  - Assert `i_rst_n` during a running pattern -> `o_led`=0 immediately, without waiting for a clock edge. After release, patterns stay 0 until rewritten.
  - With `PREWISH_MB_READBACK_EN`, a write to ch0 while ch0 plays 8'hA8 returns an active-mask value on `DAT_O` at `ACK_O`. That value is 8'hA8 rotated by the current bit index.
